// File: rtl/alu_operand_stage.sv
// Operand fetch/issue stage: decodes a 16-bit instruction, reads a 16x16 register
// file with writeback bypass, tracks pending destinations and issues to the ALU.
module alu_operand_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  input  logic [15:0] instr,
  output logic        instr_ready,
  output logic        alu_valid,
  input  logic        alu_ready,
  output logic [15:0] r1,
  output logic [15:0] r2,
  output logic [7:0]  opcode,
  output logic [3:0]  dest_addr,
  input  logic        wb_en,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  localparam logic [7:0] OPC_CMP = 8'h0B;

  state_t      state_q;
  logic [15:0] rf_q [16];
  logic [15:0] pending_q;
  logic [15:0] pending_d;
  logic [15:0] r1_q, r2_q;
  logic [7:0]  opcode_q;
  logic [3:0]  dest_q;

  logic [3:0]  op, rdest, opext, rsrc;
  logic        reg_form;
  logic [15:0] rdest_val, rsrc_val;
  logic [15:0] r1_d, r2_d;
  logic [7:0]  opcode_d;
  logic        wb_hits_rdest, wb_hits_rsrc;
  logic        hazard;
  logic        accept;

  assign op       = instr[15:12];
  assign rdest    = instr[11:8];
  assign opext    = instr[7:4];
  assign rsrc     = instr[3:0];
  assign reg_form = (op == 4'h0);

  assign wb_hits_rdest = wb_en && (wb_addr == rdest);
  assign wb_hits_rsrc  = wb_en && (wb_addr == rsrc);

  // A writeback landing this cycle both supplies the value and resolves the hazard.
  assign rdest_val = wb_hits_rdest ? wb_data : rf_q[rdest];
  assign rsrc_val  = wb_hits_rsrc  ? wb_data : rf_q[rsrc];

  always_comb begin
    r1_d     = rdest_val;
    opcode_d = reg_form ? {4'h0, opext} : {4'h0, op};
    if (reg_form) begin
      r2_d = rsrc_val;
    end else if (op == 4'h1 || op == 4'h2 || op == 4'h3) begin
      r2_d = {8'h00, instr[7:0]};
    end else begin
      r2_d = {{8{instr[7]}}, instr[7:0]};
    end
  end

  assign hazard = (pending_q[rdest] && !wb_hits_rdest) ||
                  (reg_form && pending_q[rsrc] && !wb_hits_rsrc);

  assign alu_valid   = (state_q == FULL);
  assign instr_ready = (!alu_valid || alu_ready) && !hazard;
  assign accept      = instr_valid && instr_ready;

  // Clear before set so a same-cycle retire and re-issue of one register stays pending.
  always_comb begin
    pending_d = pending_q;
    if (wb_en) begin
      pending_d[wb_addr] = 1'b0;
    end
    if (accept && (opcode_d != OPC_CMP)) begin
      pending_d[rdest] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        rf_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      if (wb_en) begin
        rf_q[wb_addr] <= wb_data;
      end
      pending_q <= pending_d;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      r1_q     <= '0;
      r2_q     <= '0;
      opcode_q <= '0;
      dest_q   <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q  <= FULL;
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            opcode_q <= opcode_d;
            dest_q   <= rdest;
          end
        end
        FULL: begin
          if (accept) begin
            r1_q     <= r1_d;
            r2_q     <= r2_d;
            opcode_q <= opcode_d;
            dest_q   <= rdest;
          end else if (alu_ready) begin
            state_q <= EMPTY;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign r1        = r1_q;
  assign r2        = r2_q;
  assign opcode    = opcode_q;
  assign dest_addr = dest_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed-vector bench for alu_operand_stage with hand-computed expected values.
module tb_alu_operand_stage;

  logic        clock;
  logic        reset_n;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic        alu_valid;
  logic        alu_ready;
  logic [15:0] r1;
  logic [15:0] r2;
  logic [7:0]  opcode;
  logic [3:0]  dest_addr;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;

  int checks_total;
  int checks_passed;

  alu_operand_stage dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_ready (instr_ready),
    .alu_valid   (alu_valid),
    .alu_ready   (alu_ready),
    .r1          (r1),
    .r2          (r2),
    .opcode      (opcode),
    .dest_addr   (dest_addr),
    .wb_en       (wb_en),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks_total++;
    if (got !== exp) begin
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      checks_passed++;
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_instr(input logic v, input logic [15:0] w);
    instr_valid = v;
    instr       = w;
    #1;
    if (v) $display("present instr %h ready=%0b", w, instr_ready);
  endtask

  task automatic set_wb(input logic en, input logic [3:0] a, input logic [15:0] d);
    wb_en   = en;
    wb_addr = a;
    wb_data = d;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [15:0] e_r1, input logic [15:0] e_r2,
                           input logic [7:0] e_op, input logic [3:0] e_dst);
    $display("issued %s: r1=%h r2=%h opcode=%h dest=%h", tag, r1, r2, opcode, dest_addr);
    check_eq({tag, ".valid"}, {15'd0, alu_valid}, 16'd1);
    check_eq({tag, ".r1"}, r1, e_r1);
    check_eq({tag, ".r2"}, r2, e_r2);
    check_eq({tag, ".opcode"}, {8'd0, opcode}, {8'd0, e_op});
    check_eq({tag, ".dest"}, {12'd0, dest_addr}, {12'd0, e_dst});
  endtask

  initial begin
    checks_total  = 0;
    checks_passed = 0;
    reset_n     = 1'b0;
    instr_valid = 1'b0;
    instr       = 16'h0000;
    alu_ready   = 1'b1;
    wb_en       = 1'b0;
    wb_addr     = 4'h0;
    wb_data     = 16'h0000;

    // Writeback attempted during reset must be ignored (R3 stays 0).
    tick();
    set_wb(1'b1, 4'h3, 16'hAAAA);
    tick();
    tick();
    check_eq("rst.valid", {15'd0, alu_valid}, 16'd0);
    check_eq("rst.r1", r1, 16'h0000);
    check_eq("rst.r2", r2, 16'h0000);
    check_eq("rst.opcode", {8'd0, opcode}, 16'h0000);
    check_eq("rst.dest", {12'd0, dest_addr}, 16'h0000);
    set_wb(1'b0, 4'h0, 16'h0000);
    reset_n = 1'b1;
    #1;
    check_eq("rst.ready", {15'd0, instr_ready}, 16'd1);

    // R1=5, R2=7, then ADD R1,R2
    set_wb(1'b1, 4'h1, 16'h0005); tick();
    set_wb(1'b1, 4'h2, 16'h0007); tick();
    set_wb(1'b0, 4'h0, 16'h0000);
    set_instr(1'b1, 16'h0152);
    check_eq("add.ready", {15'd0, instr_ready}, 16'd1);
    tick();
    set_instr(1'b0, 16'h0000);
    check_out("add", 16'h0005, 16'h0007, 8'h05, 4'h1);

    // ADDI R3,#-1: R3 must read 0 since the reset-time write was dropped
    set_instr(1'b1, 16'h53FF);
    tick();
    check_out("addi", 16'h0000, 16'hFFFF, 8'h05, 4'h3);
    // ANDI R3,#FF while R3 is pending, resolved by a same-cycle bypassed writeback
    set_instr(1'b1, 16'h13FF);
    check_eq("andi.ready_nowb", {15'd0, instr_ready}, 16'd0);
    set_wb(1'b1, 4'h3, 16'h1234);
    check_eq("andi.ready_wb", {15'd0, instr_ready}, 16'd1);
    tick();
    set_wb(1'b0, 4'h0, 16'h0000);
    set_instr(1'b0, 16'h0000);
    check_out("andi", 16'h1234, 16'h00FF, 8'h01, 4'h3);
    tick();
    check_eq("drain.valid", {15'd0, alu_valid}, 16'd0);
    // Same-cycle clear and set of pending[3] leaves it set
    set_instr(1'b1, 16'h0033);
    check_eq("pend3.ready", {15'd0, instr_ready}, 16'd0);
    set_instr(1'b0, 16'h0000);

    // Retire R3 and R1, then ADD R1,R2 followed by dependent SUB R4,R1
    set_wb(1'b1, 4'h3, 16'h1234); tick();
    set_wb(1'b1, 4'h1, 16'h0005); tick();
    set_wb(1'b0, 4'h0, 16'h0000);
    set_instr(1'b1, 16'h0152);
    tick();
    check_out("add2", 16'h0005, 16'h0007, 8'h05, 4'h1);
    set_instr(1'b1, 16'h0491);
    check_eq("sub.stall0", {15'd0, instr_ready}, 16'd0);
    tick();
    check_eq("sub.stall1", {15'd0, instr_ready}, 16'd0);
    check_eq("sub.bubble", {15'd0, alu_valid}, 16'd0);
    set_wb(1'b1, 4'h1, 16'h0009);
    check_eq("sub.ready", {15'd0, instr_ready}, 16'd1);
    tick();
    set_wb(1'b0, 4'h0, 16'h0000);
    set_instr(1'b0, 16'h0000);
    check_out("sub", 16'h0000, 16'h0009, 8'h09, 4'h4);

    // Backpressure: SUB is held for 3 cycles while ADDI R5,#3 waits
    alu_ready = 1'b0;
    set_instr(1'b1, 16'h5503);
    for (int i = 0; i < 3; i++) begin
      check_eq("bp.ready", {15'd0, instr_ready}, 16'd0);
      tick();
      check_eq("bp.hold_r2", r2, 16'h0009);
      check_eq("bp.hold_op", {8'd0, opcode}, 16'h0009);
      check_eq("bp.valid", {15'd0, alu_valid}, 16'd1);
    end
    alu_ready = 1'b1;
    #1;
    check_eq("bp.release", {15'd0, instr_ready}, 16'd1);
    tick();
    set_instr(1'b0, 16'h0000);
    check_out("addi5", 16'h0000, 16'h0003, 8'h05, 4'h5);
    tick();
    check_eq("bp.nodup", {15'd0, alu_valid}, 16'd0);

    // CMP does not mark its destination pending: no stall on back-to-back use
    set_instr(1'b1, 16'h01B2);
    tick();
    check_out("cmp", 16'h0009, 16'h0007, 8'h0B, 4'h1);
    set_instr(1'b1, 16'h0251);
    check_eq("cmp.nostall", {15'd0, instr_ready}, 16'd1);
    tick();
    check_out("add3", 16'h0007, 16'h0009, 8'h05, 4'h2);

    // ADDI R1,#1 held FULL, then asynchronous reset mid-operation
    set_instr(1'b1, 16'h5101);
    tick();
    set_instr(1'b0, 16'h0000);
    alu_ready = 1'b0;
    check_out("addi1", 16'h0009, 16'h0001, 8'h05, 4'h1);
    #2;
    reset_n = 1'b0;
    #1;
    check_eq("arst.valid", {15'd0, alu_valid}, 16'd0);
    check_eq("arst.r1", r1, 16'h0000);
    tick();
    reset_n   = 1'b1;
    alu_ready = 1'b1;
    set_instr(1'b1, 16'h0152);
    check_eq("arst.ready", {15'd0, instr_ready}, 16'd1);
    tick();
    set_instr(1'b0, 16'h0000);
    check_out("post_rst", 16'h0000, 16'h0000, 8'h05, 4'h1);

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
